// File: rtl/br_status_queue.sv
// Branch-status ring queue: multi-lane in-order allocate/retire, indexed status
// lookup, mispredict truncation after a given entry, and full pipeline flush.
module br_status_queue #(
    parameter int DATA  = 64,
    parameter int DEPTH = 8,
    parameter int WNUM  = 2,
    parameter int RNUM  = 2,
    localparam int ADDR = $clog2(DEPTH),
    localparam int CNT  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic [WNUM-1:0]      we_,
    input  logic [WNUM*DATA-1:0] wd,
    output logic [WNUM*ADDR-1:0] alloc_idx,
    input  logic [RNUM-1:0]      re_,
    output logic [RNUM*DATA-1:0] rd,
    input  logic [ADDR-1:0]      exe_st_idx,
    output logic [DATA-1:0]      exe_status,
    input  logic [ADDR-1:0]      wb_st_idx,
    input  logic                 wb_flush_,
    output logic [DATA-1:0]      wb_status,
    input  logic                 all_flush_,
    output logic [CNT-1:0]       count,
    output logic                 empty,
    output logic                 busy
);

    logic [DATA-1:0]  mem   [DEPTH];
    logic [DATA-1:0]  mem_n [DEPTH];
    logic [DEPTH-1:0] valid, valid_n;
    logic [ADDR-1:0]  head, tail, head_n, tail_n;
    logic [CNT-1:0]   count_n, wnum, rnum, kept, flush_n;
    logic [ADDR-1:0]  flush_start, slot;
    logic             wrun, rrun, mis_flush, wr_ok;

    // Ring arithmetic done one bit wider and wrapped by subtracting DEPTH.
    function automatic logic [ADDR-1:0] ring_add(input logic [ADDR-1:0] a, input logic [ADDR:0] b);
        logic [ADDR:0] s;
        s = {1'b0, a} + b;
        if (s >= (ADDR+1)'(DEPTH))
            s = s - (ADDR+1)'(DEPTH);
        return s[ADDR-1:0];
    endfunction

    function automatic logic [ADDR-1:0] ring_dist(input logic [ADDR-1:0] a, input logic [ADDR-1:0] b);
        return ring_add(a, (ADDR+1)'(DEPTH) - {1'b0, b});
    endfunction

    always_comb begin
        wnum = '0;
        wrun = 1'b1;
        for (int unsigned i = 0; i < WNUM; i++) begin
            wrun = wrun & ~we_[i];
            if (wrun)
                wnum = wnum + CNT'(1);
        end
        rnum = '0;
        rrun = 1'b1;
        for (int unsigned k = 0; k < RNUM; k++) begin
            rrun = rrun & ~re_[k] & (CNT'(k) < count);
            if (rrun)
                rnum = rnum + CNT'(1);
        end
    end

    assign mis_flush   = ~wb_flush_ && (32'(wb_st_idx) < DEPTH) && valid[wb_st_idx];
    assign kept        = CNT'(ring_dist(wb_st_idx, tail)) + CNT'(1);
    assign flush_n     = count - kept;
    assign flush_start = ring_add(wb_st_idx, (ADDR+1)'(1));
    // A retire in the same cycle frees its slots for the write, so a full
    // queue can allocate while it drains.
    assign wr_ok = ({1'b0, count} + (CNT+1)'(WNUM)) <= ((CNT+1)'(DEPTH) + {1'b0, rnum});

    always_comb begin
        mem_n   = mem;
        valid_n = valid;
        head_n  = head;
        tail_n  = ring_add(tail, (ADDR+1)'(rnum));
        count_n = count - rnum;
        slot    = '0;
        for (int unsigned k = 0; k < RNUM; k++) begin
            if (CNT'(k) < rnum) begin
                slot          = ring_add(tail, (ADDR+1)'(k));
                valid_n[slot] = 1'b0;
                mem_n[slot]   = '0;
            end
        end
        if (mis_flush) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (CNT'(ring_dist(ADDR'(j), flush_start)) < flush_n) begin
                    valid_n[j] = 1'b0;
                    mem_n[j]   = '0;
                end
            end
            head_n  = flush_start;
            count_n = kept - rnum;
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < WNUM; i++) begin
                if (CNT'(i) < wnum) begin
                    slot          = ring_add(head, (ADDR+1)'(i));
                    valid_n[slot] = 1'b1;
                    mem_n[slot]   = wd[i*DATA +: DATA];
                end
            end
            head_n  = ring_add(head, (ADDR+1)'(wnum));
            count_n = count - rnum + wnum;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            for (int unsigned j = 0; j < DEPTH; j++)
                mem[j] <= '0;
        end else if (!all_flush_) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            for (int unsigned j = 0; j < DEPTH; j++)
                mem[j] <= '0;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
            valid <= valid_n;
            for (int unsigned j = 0; j < DEPTH; j++)
                mem[j] <= mem_n[j];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WNUM; i++)
            alloc_idx[i*ADDR +: ADDR] = ring_add(head, (ADDR+1)'(i));
        for (int unsigned k = 0; k < RNUM; k++)
            rd[k*DATA +: DATA] = (CNT'(k) < count) ? mem[ring_add(tail, (ADDR+1)'(k))] : '0;
        exe_status = (32'(exe_st_idx) < DEPTH) ? mem[exe_st_idx] : '0;
        wb_status  = (32'(wb_st_idx) < DEPTH) ? mem[wb_st_idx] : '0;
    end

    assign empty = (count == '0);
    assign busy  = ({1'b0, count} + (CNT+1)'(WNUM)) > (CNT+1)'(DEPTH);

endmodule
